// File: rtl/redmule_cfg_tiler_if.sv
// Request/result bundle between the register file, the tiler and the scheduler.
// The slave modport is the tiler side; the master modport is the requester/consumer side.
interface redmule_cfg_tiler_if;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [15:0] m_size_i;
    logic [15:0] n_size_i;
    logic [15:0] k_size_i;
    logic        fmt_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] x_rows_iter_o;
    logic [15:0] x_cols_iter_o;
    logic [15:0] w_rows_iter_o;
    logic [15:0] w_cols_iter_o;
    logic [7:0]  x_rows_lftovr_o;
    logic [7:0]  x_cols_lftovr_o;
    logic [7:0]  w_rows_lftovr_o;
    logic [7:0]  w_cols_lftovr_o;
    logic [15:0] tot_stores_o;
    logic [31:0] x_d1_stride_o;
    logic [31:0] w_d0_stride_o;
    logic [31:0] yz_d0_stride_o;
    logic [31:0] yz_d2_stride_o;
    logic        small_n_o;
    logic        small_k_o;
    logic        err_o;
    logic        ovf_o;

    modport slave (
        input  cfg_valid_i, m_size_i, n_size_i, k_size_i, fmt_i, out_ready_i,
        output cfg_ready_o, out_valid_o,
               x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o,
               x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o,
               tot_stores_o, x_d1_stride_o, w_d0_stride_o, yz_d0_stride_o, yz_d2_stride_o,
               small_n_o, small_k_o, err_o, ovf_o
    );

    modport master (
        output cfg_valid_i, m_size_i, n_size_i, k_size_i, fmt_i, out_ready_i,
        input  cfg_ready_o, out_valid_o,
               x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o,
               x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o,
               tot_stores_o, x_d1_stride_o, w_d0_stride_o, yz_d0_stride_o, yz_d2_stride_o,
               small_n_o, small_k_o, err_o, ovf_o
    );
endinterface

// File: rtl/redmule_cfg_tiler.sv
// GEMM tiling calculator: one shared restoring divider and one shift-add multiplier.
// Latency 64 cycles accept-to-valid (0 for zero-size); results held until out_ready_i, one-cycle bubble after.
// Stride outputs exist only when REDMULE_TILER_STRIDES_EN is defined, otherwise they are tied to 0.
module redmule_cfg_tiler #(
    parameter int unsigned ARRAY_WIDTH  = 12,
    parameter int unsigned ARRAY_HEIGHT = 4,
    parameter int unsigned PIPE_REGS    = 3,
    parameter int unsigned DATA_W       = 288,
    parameter int unsigned MEMDW        = 32
) (
    input  logic                clk_i,
    input  logic                clear_i,
    redmule_cfg_tiler_if.slave  bus
);
    localparam int unsigned TILE = (PIPE_REGS + 1) * ARRAY_HEIGHT;
    localparam logic [7:0]  D16  = 8'((DATA_W - MEMDW) / 16);
    localparam logic [7:0]  D8   = 8'((DATA_W - MEMDW) / 8);
    localparam logic [7:0]  AW   = 8'(ARRAY_WIDTH);
    localparam logic [15:0] AH   = 16'(ARRAY_HEIGHT);
    localparam logic [15:0] TL   = 16'(TILE);

    typedef enum logic [2:0] {IDLE, DIV_M, DIV_N, DIV_K, MUL, DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]  cnt;
    logic [15:0] m_q, n_q, k_q;
    logic        fmt_q;
    logic [15:0] dq;
    logic [7:0]  rem;
    logic [31:0] mul_a, mul_acc;
    logic [15:0] xr_iter, xc_iter, wc_iter;
    logic [7:0]  xr_lft, xc_lft, wc_lft;

    logic [15:0] x_rows_iter_q, x_cols_iter_q, w_rows_iter_q, w_cols_iter_q, tot_stores_q;
    logic [7:0]  x_rows_lftovr_q, x_cols_lftovr_q, w_rows_lftovr_q, w_cols_lftovr_q;
    logic        small_n_q, small_k_q, err_q, ovf_q;

    logic        accept, zero_req, last, load_res, load_zero, ge, ovf_nxt;
    logic [7:0]  divisor, rem_nxt;
    logic [8:0]  trial, diff;
    logic [15:0] q_nxt, iter_nxt;
    logic [31:0] prod_nxt;

    assign accept    = bus.cfg_valid_i && (state == IDLE);
    assign zero_req  = (bus.m_size_i == 16'd0) || (bus.n_size_i == 16'd0) || (bus.k_size_i == 16'd0);
    assign last      = (cnt == 4'hF);
    assign load_res  = (state == MUL) && last;
    assign load_zero = accept && zero_req;

    // One restoring step; remainder stays below the 8-bit divisor, so bit 8 of diff is the borrow.
    assign divisor  = (state == DIV_M) ? AW : (fmt_q ? D8 : D16);
    assign trial    = {rem, dq[15]};
    assign diff     = trial - {1'b0, divisor};
    assign ge       = ~diff[8];
    assign rem_nxt  = ge ? diff[7:0] : trial[7:0];
    assign q_nxt    = {dq[14:0], ge};
    assign iter_nxt = q_nxt + {15'd0, (rem_nxt != 8'd0)};

    // During MUL, dq holds the multiplier and shifts right one bit per cycle.
    assign prod_nxt = mul_acc + (dq[0] ? mul_a : 32'd0);
    assign ovf_nxt  = |prod_nxt[31:16];

    always_ff @(posedge clk_i) begin
        if (clear_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_req ? DONE : DIV_M;
            DIV_M:   if (last) state_nxt = DIV_N;
            DIV_N:   if (last) state_nxt = DIV_K;
            DIV_K:   if (last) state_nxt = MUL;
            MUL:     if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cnt <= '0; m_q <= '0; n_q <= '0; k_q <= '0; fmt_q <= 1'b0;
            dq <= '0; rem <= '0; mul_a <= '0; mul_acc <= '0;
            xr_iter <= '0; xc_iter <= '0; wc_iter <= '0;
            xr_lft <= '0; xc_lft <= '0; wc_lft <= '0;
            x_rows_iter_q <= '0; x_cols_iter_q <= '0; w_rows_iter_q <= '0; w_cols_iter_q <= '0;
            x_rows_lftovr_q <= '0; x_cols_lftovr_q <= '0; w_rows_lftovr_q <= '0; w_cols_lftovr_q <= '0;
            tot_stores_q <= '0; small_n_q <= 1'b0; small_k_q <= 1'b0; err_q <= 1'b0; ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_q   <= bus.m_size_i;
                        n_q   <= bus.n_size_i;
                        k_q   <= bus.k_size_i;
                        fmt_q <= bus.fmt_i;
                        dq    <= bus.m_size_i;
                        rem   <= '0;
                        cnt   <= '0;
                    end
                    if (load_zero) begin
                        x_rows_iter_q <= '0; x_cols_iter_q <= '0; w_rows_iter_q <= '0; w_cols_iter_q <= '0;
                        x_rows_lftovr_q <= '0; x_cols_lftovr_q <= '0; w_rows_lftovr_q <= '0; w_cols_lftovr_q <= '0;
                        tot_stores_q <= '0; small_n_q <= 1'b0; small_k_q <= 1'b0; err_q <= 1'b1; ovf_q <= 1'b0;
                    end
                end
                DIV_M, DIV_N, DIV_K: begin
                    cnt <= cnt + 4'd1;
                    dq  <= q_nxt;
                    rem <= rem_nxt;
                    if (last) begin
                        rem <= '0;
                        if (state == DIV_M) begin
                            xr_iter <= iter_nxt; xr_lft <= rem_nxt; dq <= n_q;
                        end else if (state == DIV_N) begin
                            xc_iter <= iter_nxt; xc_lft <= rem_nxt; dq <= k_q;
                        end else begin
                            wc_iter <= iter_nxt; wc_lft <= rem_nxt; dq <= iter_nxt;
                            mul_a   <= {16'd0, xr_iter};
                            mul_acc <= '0;
                        end
                    end
                end
                MUL: begin
                    cnt     <= cnt + 4'd1;
                    mul_acc <= prod_nxt;
                    mul_a   <= {mul_a[30:0], 1'b0};
                    dq      <= {1'b0, dq[15:1]};
                    if (last) begin
                        x_rows_iter_q   <= xr_iter;
                        x_cols_iter_q   <= xc_iter;
                        w_rows_iter_q   <= n_q;
                        w_cols_iter_q   <= wc_iter;
                        x_rows_lftovr_q <= xr_lft;
                        x_cols_lftovr_q <= xc_lft;
                        w_rows_lftovr_q <= 8'(n_q % AH);
                        w_cols_lftovr_q <= wc_lft;
                        tot_stores_q    <= ovf_nxt ? 16'hFFFF : prod_nxt[15:0];
                        ovf_q           <= ovf_nxt;
                        err_q           <= 1'b0;
                        small_n_q       <= (n_q < AH);
                        small_k_q       <= (k_q < TL);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REDMULE_TILER_STRIDES_EN
    logic [31:0] nb, kb;
    logic [31:0] x_d1_q, w_d0_q, yz_d0_q, yz_d2_q;

    assign nb = fmt_q ? {16'd0, n_q} : {15'd0, n_q, 1'b0};
    assign kb = fmt_q ? {16'd0, k_q} : {15'd0, k_q, 1'b0};

    always_ff @(posedge clk_i) begin
        if (clear_i || load_zero) begin
            x_d1_q <= '0; w_d0_q <= '0; yz_d0_q <= '0; yz_d2_q <= '0;
        end else if (load_res) begin
            x_d1_q  <= nb;
            w_d0_q  <= kb;
            yz_d0_q <= kb;
            yz_d2_q <= kb * 32'(ARRAY_WIDTH);
        end
    end

    assign bus.x_d1_stride_o  = x_d1_q;
    assign bus.w_d0_stride_o  = w_d0_q;
    assign bus.yz_d0_stride_o = yz_d0_q;
    assign bus.yz_d2_stride_o = yz_d2_q;
`else
    assign bus.x_d1_stride_o  = '0;
    assign bus.w_d0_stride_o  = '0;
    assign bus.yz_d0_stride_o = '0;
    assign bus.yz_d2_stride_o = '0;
`endif

    assign bus.cfg_ready_o     = (state == IDLE);
    assign bus.out_valid_o     = (state == DONE);
    assign bus.x_rows_iter_o   = x_rows_iter_q;
    assign bus.x_cols_iter_o   = x_cols_iter_q;
    assign bus.w_rows_iter_o   = w_rows_iter_q;
    assign bus.w_cols_iter_o   = w_cols_iter_q;
    assign bus.x_rows_lftovr_o = x_rows_lftovr_q;
    assign bus.x_cols_lftovr_o = x_cols_lftovr_q;
    assign bus.w_rows_lftovr_o = w_rows_lftovr_q;
    assign bus.w_cols_lftovr_o = w_cols_lftovr_q;
    assign bus.tot_stores_o    = tot_stores_q;
    assign bus.small_n_o       = small_n_q;
    assign bus.small_k_o       = small_k_q;
    assign bus.err_o           = err_q;
    assign bus.ovf_o           = ovf_q;
endmodule

// File: tb/tb_redmule_cfg_tiler.sv
// Directed bench for redmule_cfg_tiler with hand-computed expectations (12x4 array, 288-bit port).
module tb_redmule_cfg_tiler;
    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    redmule_cfg_tiler_if bus();

    redmule_cfg_tiler dut (
        .clk_i   (clk),
        .clear_i (clear),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v);
`ifdef REDMULE_TILER_STRIDES_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Present a request for one edge, then scramble the inputs to prove they were latched.
    task automatic start_req(input logic [15:0] m, input logic [15:0] n, input logic [15:0] k, input logic f);
        @(negedge clk);
        bus.cfg_valid_i = 1'b1;
        bus.m_size_i = m; bus.n_size_i = n; bus.k_size_i = k; bus.fmt_i = f;
        @(posedge clk);
        #1;
        bus.cfg_valid_i = 1'b0;
        bus.m_size_i = 16'hDEAD; bus.n_size_i = 16'h0000; bus.k_size_i = 16'h0003; bus.fmt_i = ~f;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid_o || n >= 200) break;
            @(posedge clk);
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        bus.cfg_valid_i = 1'b0; bus.out_ready_i = 1'b0;
        bus.m_size_i = '0; bus.n_size_i = '0; bus.k_size_i = '0; bus.fmt_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_ready", bus.cfg_ready_o, 1);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_tot_stores", bus.tot_stores_o, 0);
        chk("rst_x_rows_iter", bus.x_rows_iter_o, 0);
        chk("rst_err", bus.err_o, 0);
        clear = 1'b0;

        // FP16 96x64x64: everything divides evenly
        start_req(16'd96, 16'd64, 16'd64, 1'b0);
        wait_valid(lat);
        chk("t1_latency", lat, 64);
        chk("t1_x_rows_iter", bus.x_rows_iter_o, 8);
        chk("t1_x_cols_iter", bus.x_cols_iter_o, 4);
        chk("t1_w_cols_iter", bus.w_cols_iter_o, 4);
        chk("t1_w_rows_iter", bus.w_rows_iter_o, 64);
        chk("t1_lftovrs", {bus.x_rows_lftovr_o, bus.x_cols_lftovr_o, bus.w_rows_lftovr_o, bus.w_cols_lftovr_o}, 0);
        chk("t1_tot_stores", bus.tot_stores_o, 32);
        chk("t1_x_d1_stride", bus.x_d1_stride_o, sx(128));
        chk("t1_w_d0_stride", bus.w_d0_stride_o, sx(128));
        chk("t1_yz_d0_stride", bus.yz_d0_stride_o, sx(128));
        chk("t1_yz_d2_stride", bus.yz_d2_stride_o, sx(1536));
        chk("t1_flags", {bus.small_n_o, bus.small_k_o, bus.err_o, bus.ovf_o}, 0);
        chk("t1_cfg_ready_busy", bus.cfg_ready_o, 0);
        consume();

        // FP16 13x17x3: leftovers everywhere, small K
        start_req(16'd13, 16'd17, 16'd3, 1'b0);
        wait_valid(lat);
        chk("t2_latency", lat, 64);
        chk("t2_x_rows", {bus.x_rows_iter_o, bus.x_rows_lftovr_o}, {16'd2, 8'd1});
        chk("t2_x_cols", {bus.x_cols_iter_o, bus.x_cols_lftovr_o}, {16'd2, 8'd1});
        chk("t2_w_cols", {bus.w_cols_iter_o, bus.w_cols_lftovr_o}, {16'd1, 8'd3});
        chk("t2_w_rows", {bus.w_rows_iter_o, bus.w_rows_lftovr_o}, {16'd17, 8'd1});
        chk("t2_tot_stores", bus.tot_stores_o, 2);
        chk("t2_flags", {bus.small_n_o, bus.small_k_o, bus.err_o, bus.ovf_o}, 4'b0100);
        chk("t2_x_d1_stride", bus.x_d1_stride_o, sx(34));
        consume();

        // FP8 12x33x64: 32 elements per beat
        start_req(16'd12, 16'd33, 16'd64, 1'b1);
        wait_valid(lat);
        chk("t3_x_rows", {bus.x_rows_iter_o, bus.x_rows_lftovr_o}, {16'd1, 8'd0});
        chk("t3_x_cols", {bus.x_cols_iter_o, bus.x_cols_lftovr_o}, {16'd2, 8'd1});
        chk("t3_w_cols", {bus.w_cols_iter_o, bus.w_cols_lftovr_o}, {16'd2, 8'd0});
        chk("t3_tot_stores", bus.tot_stores_o, 2);
        chk("t3_x_d1_stride", bus.x_d1_stride_o, sx(33));
        chk("t3_w_d0_stride", bus.w_d0_stride_o, sx(64));
        chk("t3_yz_d2_stride", bus.yz_d2_stride_o, sx(768));
        consume();

        // Zero N: immediate error result
        start_req(16'd5, 16'd0, 16'd7, 1'b0);
        wait_valid(lat);
        chk("t4_latency", lat, 0);
        chk("t4_err", bus.err_o, 1);
        chk("t4_iters", {bus.x_rows_iter_o, bus.x_cols_iter_o, bus.w_cols_iter_o, bus.w_rows_iter_o}, 0);
        chk("t4_lftovrs", {bus.x_rows_lftovr_o, bus.x_cols_lftovr_o, bus.w_rows_lftovr_o, bus.w_cols_lftovr_o}, 0);
        chk("t4_tot_stores", bus.tot_stores_o, 0);
        chk("t4_strides", bus.x_d1_stride_o | bus.w_d0_stride_o | bus.yz_d0_stride_o | bus.yz_d2_stride_o, 0);
        consume();

        // FP8 65535x1x65535: store count saturates
        start_req(16'd65535, 16'd1, 16'd65535, 1'b1);
        wait_valid(lat);
        chk("t5_latency", lat, 64);
        chk("t5_x_rows", {bus.x_rows_iter_o, bus.x_rows_lftovr_o}, {16'd5462, 8'd3});
        chk("t5_x_cols", {bus.x_cols_iter_o, bus.x_cols_lftovr_o}, {16'd1, 8'd1});
        chk("t5_w_cols", {bus.w_cols_iter_o, bus.w_cols_lftovr_o}, {16'd2048, 8'd31});
        chk("t5_tot_stores", bus.tot_stores_o, 32'hFFFF);
        chk("t5_flags", {bus.small_n_o, bus.small_k_o, bus.err_o, bus.ovf_o}, 4'b1001);
        chk("t5_yz_d2_stride", bus.yz_d2_stride_o, sx(786420));

        // Backpressure: hold results with a competing request pending
        bus.cfg_valid_i = 1'b1;
        bus.m_size_i = 16'd1; bus.n_size_i = 16'd1; bus.k_size_i = 16'd1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_out_valid", bus.out_valid_o, 1);
        chk("bp_cfg_ready", bus.cfg_ready_o, 0);
        chk("bp_tot_stores", bus.tot_stores_o, 32'hFFFF);
        chk("bp_x_rows_iter", bus.x_rows_iter_o, 5462);
        bus.cfg_valid_i = 1'b0;
        consume();
        @(negedge clk);
        chk("post_cfg_ready", bus.cfg_ready_o, 1);
        chk("post_out_valid", bus.out_valid_o, 0);
        chk("post_hold_tot", bus.tot_stores_o, 32'hFFFF);

        // Clear in the middle of a computation
        start_req(16'd96, 16'd64, 16'd64, 1'b0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        chk("mid_hold_tot", bus.tot_stores_o, 32'hFFFF);
        chk("mid_cfg_ready", bus.cfg_ready_o, 0);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        chk("clr_cfg_ready", bus.cfg_ready_o, 1);
        chk("clr_out_valid", bus.out_valid_o, 0);
        chk("clr_tot_stores", bus.tot_stores_o, 0);
        chk("clr_x_rows_iter", bus.x_rows_iter_o, 0);
        chk("clr_flags", {bus.small_n_o, bus.small_k_o, bus.err_o, bus.ovf_o}, 0);

        // Operational again after clear
        start_req(16'd24, 16'd4, 16'd32, 1'b0);
        wait_valid(lat);
        chk("t7_latency", lat, 64);
        chk("t7_x_rows", {bus.x_rows_iter_o, bus.x_rows_lftovr_o}, {16'd2, 8'd0});
        chk("t7_x_cols", {bus.x_cols_iter_o, bus.x_cols_lftovr_o}, {16'd1, 8'd4});
        chk("t7_w_cols", {bus.w_cols_iter_o, bus.w_cols_lftovr_o}, {16'd2, 8'd0});
        chk("t7_tot_stores", bus.tot_stores_o, 4);
        chk("t7_w_rows_lftovr", bus.w_rows_lftovr_o, 0);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
